// File: rtl/trigger_sequence_pkg.sv
// Shared state encoding and default widths for the trigger sequence controller.
package trigger_sequence_pkg;

    localparam int FRAME_COUNT_WIDTH_DEF  = 16;
    localparam int SAMPLE_COUNT_WIDTH_DEF = 32;
    localparam int GAP_WIDTH_DEF          = 16;
    localparam int TIMEOUT_WIDTH_DEF      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_ARMED,
        ST_WAIT_TRIG,
        ST_ACQUIRE,
        ST_CLEAR,
        ST_GAP,
        ST_FINISH
    } seq_state_t;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trigger_sequence_down_counter.sv
// Loadable down counter with a zero flag; shared between the acquisition
// window and the re-arm gap, which never overlap.
module trigger_sequence_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/trigger_sequence_controller.sv
// Multi-frame acquisition sequencer for the counter-delayed trigger block.
// Optional trigger-wait timeout enabled by defining TRIGGER_SEQUENCE_TIMEOUT_EN.
module trigger_sequence_controller
    import trigger_sequence_pkg::*;
#(
    parameter int FRAME_COUNT_WIDTH  = FRAME_COUNT_WIDTH_DEF,
    parameter int SAMPLE_COUNT_WIDTH = SAMPLE_COUNT_WIDTH_DEF,
    parameter int GAP_WIDTH          = GAP_WIDTH_DEF,
    parameter int TIMEOUT_WIDTH      = TIMEOUT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic                          start,
    input  logic                          abort,
    input  logic [FRAME_COUNT_WIDTH-1:0]  num_frames,
    input  logic [SAMPLE_COUNT_WIDTH-1:0] frame_samples,
    input  logic [GAP_WIDTH-1:0]          rearm_gap,
    input  logic [TIMEOUT_WIDTH-1:0]      timeout_cycles,
    input  logic                          trigger,
    input  logic                          armed_status,
    output logic                          arm,
    output logic                          trigger_reset,
    output logic                          acq_window,
    output logic [FRAME_COUNT_WIDTH-1:0]  frame_count,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout
);

    localparam int CNT_WIDTH = max_width(SAMPLE_COUNT_WIDTH, GAP_WIDTH);

    seq_state_t state;
    seq_state_t state_next;

    logic [FRAME_COUNT_WIDTH-1:0]  lat_num_frames;
    logic [SAMPLE_COUNT_WIDTH-1:0] lat_frame_samples;
    logic [GAP_WIDTH-1:0]          lat_rearm_gap;
    logic [FRAME_COUNT_WIDTH-1:0]  frame_count_inc;

    logic                 trig_q;
    logic                 trig_edge;
    logic                 stop_req;
    logic                 stop_flag;
    logic                 timeout_hit;
    logic                 start_run;
    logic                 set_stop;
    logic                 set_timeout;
    logic                 count_frame;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic [CNT_WIDTH-1:0] cnt_load_value;

    assign stop_req        = abort | ~enable;
    assign trig_edge       = trigger & ~trig_q;
    assign frame_count_inc = (&frame_count) ? frame_count
                                            : frame_count + FRAME_COUNT_WIDTH'(1);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            lat_num_frames    <= '0;
            lat_frame_samples <= '0;
            lat_rearm_gap     <= '0;
        end else if (start_run) begin
            lat_num_frames    <= num_frames;
            lat_frame_samples <= frame_samples;
            lat_rearm_gap     <= rearm_gap;
        end
    end

    // stop_flag marks a CLEAR entered by abort/disable/timeout: no count, no done
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            trig_q    <= 1'b0;
            stop_flag <= 1'b0;
        end else begin
            trig_q    <= trigger;
            stop_flag <= set_stop;
        end
    end

`ifdef TRIGGER_SEQUENCE_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] lat_timeout;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            lat_timeout <= '0;
        end else if (start_run) begin
            lat_timeout <= timeout_cycles;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT_TRIG) begin
            wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = (state == ST_WAIT_TRIG) && (lat_timeout != '0)
                      && (wait_cnt == lat_timeout - TIMEOUT_WIDTH'(1));
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_hit    = 1'b0;
`endif

    trigger_sequence_down_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_down_counter (
        .clk        (clk),
        .aresetn    (aresetn),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter is loaded with N-1 so that a phase lasts exactly N cycles
    always_comb begin
        state_next     = state;
        start_run      = 1'b0;
        set_stop       = 1'b0;
        set_timeout    = 1'b0;
        count_frame    = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        cnt_load_value = '0;
        case (state)
            ST_IDLE: begin
                if (start && enable && !abort) begin
                    start_run  = 1'b1;
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                state_next = stop_req ? ST_IDLE : ST_WAIT_ARMED;
            end
            ST_WAIT_ARMED: begin
                if (stop_req) begin
                    state_next = ST_IDLE;
                end else if (armed_status) begin
                    state_next = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (stop_req) begin
                    set_stop   = 1'b1;
                    state_next = ST_CLEAR;
                end else if (trig_edge) begin
                    if (lat_frame_samples == '0) begin
                        state_next = ST_CLEAR;
                    end else begin
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_WIDTH'(lat_frame_samples - SAMPLE_COUNT_WIDTH'(1));
                        state_next     = ST_ACQUIRE;
                    end
                end else if (timeout_hit) begin
                    set_stop    = 1'b1;
                    set_timeout = 1'b1;
                    state_next  = ST_CLEAR;
                end
            end
            ST_ACQUIRE: begin
                if (stop_req) begin
                    set_stop   = 1'b1;
                    state_next = ST_CLEAR;
                end else if (cnt_zero) begin
                    state_next = ST_CLEAR;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (stop_flag) begin
                    state_next = ST_IDLE;
                end else begin
                    count_frame = 1'b1;
                    if (stop_req) begin
                        state_next = ST_IDLE;
                    end else if ((lat_num_frames != '0) && (frame_count_inc == lat_num_frames)) begin
                        state_next = ST_FINISH;
                    end else if (lat_rearm_gap == '0) begin
                        state_next = ST_ARM;
                    end else begin
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_WIDTH'(lat_rearm_gap - GAP_WIDTH'(1));
                        state_next     = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop_req) begin
                    state_next = ST_IDLE;
                end else if (cnt_zero) begin
                    state_next = ST_ARM;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            arm           <= 1'b0;
            trigger_reset <= 1'b0;
            acq_window    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            arm           <= (state_next == ST_ARM);
            trigger_reset <= (state_next == ST_CLEAR);
            acq_window    <= (state_next == ST_ACQUIRE);
            busy          <= (state_next != ST_IDLE);
            done          <= (state_next == ST_FINISH);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
            timeout     <= 1'b0;
        end else if (start_run) begin
            frame_count <= '0;
            timeout     <= 1'b0;
        end else begin
            if (count_frame) begin
                frame_count <= frame_count_inc;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trigger_sequence_controller.sv
// Randomized bench: each run is planned as a per-cycle timeline of expected
// outputs derived from the sequencing rules, then replayed against the DUT.
module tb_trigger_sequence_controller;

    localparam int MAXC = 512;
    localparam int E_BUSY = 0, E_ARM = 1, E_ACQ = 2, E_TRST = 3, E_DONE = 4, E_TO = 5;
    localparam int P_START = 0, P_ABORT = 1, P_EN = 2, P_TRIG = 3, P_ARMED = 4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        start;
    logic        abort;
    logic [15:0] num_frames;
    logic [31:0] frame_samples;
    logic [15:0] rearm_gap;
    logic [31:0] timeout_cycles;
    logic        trigger;
    logic        armed_status;
    logic        arm;
    logic        trigger_reset;
    logic        acq_window;
    logic [15:0] frame_count;
    logic        busy;
    logic        done;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    bit ex[6][MAXC];
    bit pl[5][MAXC];
    int ex_fc[MAXC];
    int plan_len, plan_nf, plan_fs, plan_gap, plan_to;
    int run_id   = 0;
    int model_fc = 0;
    bit model_to = 1'b0;

    always #5 clk = ~clk;

    trigger_sequence_controller dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .enable         (enable),
        .start          (start),
        .abort          (abort),
        .num_frames     (num_frames),
        .frame_samples  (frame_samples),
        .rearm_gap      (rearm_gap),
        .timeout_cycles (timeout_cycles),
        .trigger        (trigger),
        .armed_status   (armed_status),
        .arm            (arm),
        .trigger_reset  (trigger_reset),
        .acq_window     (acq_window),
        .frame_count    (frame_count),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic markEx(input int sig, input int lo, input int hi);
        for (int c = lo; c <= hi && c < MAXC; c++) ex[sig][c] = 1'b1;
    endtask

    task automatic markPl(input int sig, input int lo, input int hi);
        for (int c = lo; c <= hi && c < MAXC; c++) pl[sig][c] = 1'b1;
    endtask

    // stop_kind: 0 normal end, 1 abort in 4th acquire cycle, 2 enable low while
    // waiting for armed, 3 no trigger (timeout or abort), 4 stop plan mid-gap
    task automatic planRun(input int nf, input int frames, input int fs, input int gap,
                           input bit pre_high, input int stop_kind, input int to_cyc);
        int a, w, e, r, d1, last_busy, fc;
        bit last;
        for (int s = 0; s < 6; s++) for (int c = 0; c < MAXC; c++) ex[s][c] = 1'b0;
        for (int s = 0; s < 5; s++) for (int c = 0; c < MAXC; c++) pl[s][c] = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            pl[P_EN][c] = 1'b1;
            ex_fc[c]    = 0;
        end
        run_id++;
        plan_nf = nf; plan_fs = fs; plan_gap = gap; plan_to = to_cyc;
        pl[P_START][0] = 1'b1;
        ex_fc[0]       = model_fc;
        ex[E_TO][0]    = model_to;
        fc = 0; a = 1; last_busy = 0;
        for (int k = 0; k < frames; k++) begin
            last = (k == frames - 1);
            ex[E_ARM][a] = 1'b1;
            d1 = $urandom_range(1, 3);
            w  = a + d1 + 1;
            if (last && stop_kind == 2) begin
                pl[P_EN][a + 1] = 1'b0;
                last_busy = a + 1;
                break;
            end
            if (last && stop_kind == 3) begin
`ifdef TRIGGER_SEQUENCE_TIMEOUT_EN
                r = w + to_cyc;
                markEx(E_TO, r, MAXC - 1);
`else
                pl[P_ABORT][w + 10] = 1'b1;
                r = w + 11;
`endif
                markPl(P_ARMED, a + d1, r);
                ex[E_TRST][r] = 1'b1;
                last_busy = r;
                break;
            end
            if (pre_high) begin
                markPl(P_TRIG, w - 1, w + 2);
                e = w + 5;
            end else begin
                e = w + $urandom_range(0, 4);
            end
            if (last && stop_kind == 1) begin
                pl[P_ABORT][e + 4] = 1'b1;
                markEx(E_ACQ, e + 1, e + 4);
                r = e + 5;
                markPl(P_ARMED, a + d1, r);
                markPl(P_TRIG, e, r);
                ex[E_TRST][r] = 1'b1;
                last_busy = r;
                break;
            end
            markEx(E_ACQ, e + 1, e + fs);
            r = e + fs + 1;
            markPl(P_ARMED, a + d1, r);
            markPl(P_TRIG, e, r);
            ex[E_TRST][r] = 1'b1;
            fc++;
            for (int c = r + 1; c < MAXC; c++) ex_fc[c] = fc;
            if (last) begin
                if (stop_kind == 4) begin
                    last_busy = r + 2;
                end else begin
                    ex[E_DONE][r + 1] = 1'b1;
                    last_busy = r + 1;
                end
            end else begin
                a = r + gap + 1;
            end
        end
        markEx(E_BUSY, 1, last_busy);
        plan_len = (stop_kind == 4) ? last_busy + 1 : last_busy + 4;
        model_fc = ex_fc[plan_len - 1];
        model_to = ex[E_TO][plan_len - 1];
    endtask

    task automatic applyStimulus();
        for (int c = 0; c < plan_len; c++) begin
            @(negedge clk);
            checkOutput($sformatf("run%0d cyc%0d flags{busy,arm,acq,trst,done,to}", run_id, c),
                        {26'd0, busy, arm, acq_window, trigger_reset, done, timeout},
                        {26'd0, ex[E_BUSY][c], ex[E_ARM][c], ex[E_ACQ][c], ex[E_TRST][c],
                         ex[E_DONE][c], ex[E_TO][c]});
            checkOutput($sformatf("run%0d cyc%0d frame_count", run_id, c),
                        {16'd0, frame_count}, ex_fc[c]);
            start        = pl[P_START][c];
            abort        = pl[P_ABORT][c];
            enable       = pl[P_EN][c];
            trigger      = pl[P_TRIG][c];
            armed_status = pl[P_ARMED][c];
            if (c == 0) begin
                num_frames     = 16'(plan_nf);
                frame_samples  = 32'(plan_fs);
                rearm_gap      = 16'(plan_gap);
                timeout_cycles = 32'(plan_to);
            end else begin
                num_frames     = 16'($urandom);
                frame_samples  = $urandom;
                rearm_gap      = 16'($urandom);
                timeout_cycles = $urandom;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn = 1'b0; enable = 1'b1; start = 1'b0; abort = 1'b0;
        trigger = 1'b0; armed_status = 1'b0;
        num_frames = '0; frame_samples = '0; rearm_gap = '0; timeout_cycles = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset flags", {26'd0, busy, arm, acq_window, trigger_reset, done, timeout}, 32'd0);
        checkOutput("reset frame_count", {16'd0, frame_count}, 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);

        planRun(3, 3, 10, 5, 1'b0, 0, 0);   applyStimulus();
        planRun(1, 1, 0, 3, 1'b0, 0, 0);    applyStimulus();
        planRun(1, 1, 6, 2, 1'b1, 0, 0);    applyStimulus();
        planRun(2, 2, 20, 4, 1'b0, 1, 0);   applyStimulus();
        planRun(5, 1, 8, 3, 1'b0, 3, 100);  applyStimulus();
        planRun(2, 2, 7, 0, 1'b0, 0, 0);    applyStimulus();
        planRun(4, 2, 5, 2, 1'b0, 2, 0);    applyStimulus();

        planRun(0, 2, 5, 8, 1'b0, 4, 0);    applyStimulus();
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("async reset flags", {26'd0, busy, arm, acq_window, trigger_reset, done, timeout}, 32'd0);
        checkOutput("async reset frame_count", {16'd0, frame_count}, 32'd0);
        repeat (3) @(negedge clk);
        aresetn  = 1'b1;
        model_fc = 0;
        model_to = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset idle cyc%0d", i),
                        {26'd0, busy, arm, acq_window, trigger_reset, done, timeout}, 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            int nf;
            nf = $urandom_range(1, 4);
            planRun(nf, nf, $urandom_range(0, 12), $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), 0, 0);
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
